// File: rtl/ex_mem_stage_pkg.sv
// Shared constants and helpers for the EX/MEM pipeline stage.
package ex_mem_stage_pkg;

    localparam int unsigned FLAG_W     = 3;
    localparam int unsigned CCR_C      = 2;
    localparam int unsigned CCR_S      = 1;
    localparam int unsigned CCR_Z      = 0;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 5;

    // Merge new flag values into the current CCR wherever the mask bit is set.
    function automatic logic [FLAG_W-1:0] maskMerge(
        input logic [FLAG_W-1:0] cur,
        input logic [FLAG_W-1:0] nxt,
        input logic [FLAG_W-1:0] mask
    );
        return (cur & ~mask) | (nxt & mask);
    endfunction

endpackage

// File: rtl/ex_mem_stage_ccr_unit.sv
// Condition-code register with a one-deep shadow for interrupt entry / RTI.
module ccr_unit
    import ex_mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    input  logic              update,
    input  logic [FLAG_W-1:0] flagMask,
    input  logic [FLAG_W-1:0] flagsIn,
    input  logic              intSave,
    input  logic              rtiRestore,
    output logic [FLAG_W-1:0] ccr
);

    logic [FLAG_W-1:0] shadow;
    logic [FLAG_W-1:0] ccrNext;

    // Next CCR: masked ALU update, overridden entirely by an RTI restore.
    always_comb begin
        ccrNext = ccr;
        if (update) begin
            ccrNext = maskMerge(ccr, flagsIn, flagMask);
        end
        if (rtiRestore) begin
            ccrNext = shadow;
        end
    end

    // CCR and shadow registers; shadow samples the pre-edge CCR so save+restore swaps.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ccr    <= '0;
            shadow <= '0;
        end else begin
            ccr <= ccrNext;
            if (intSave) begin
                shadow <= ccr;
            end
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: handshake, payload registers, HI register and CCR.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] aluResultExt,
    input  logic              carryIn,
    input  logic              signIn,
    input  logic              zeroIn,
    input  logic [FLAG_W-1:0] flagMask,
    input  logic              hiWrite,
    input  logic [REG_AW-1:0] rdIn,
    input  logic              regWriteIn,
    input  logic              memReadIn,
    input  logic              memWriteIn,
    input  logic [DATA_W-1:0] storeDataIn,
    input  logic              flush,
    input  logic              intSave,
    input  logic              rtiRestore,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] resultOut,
    output logic [DATA_W-1:0] storeDataOut,
    output logic [REG_AW-1:0] rdOut,
    output logic              regWriteOut,
    output logic              memReadOut,
    output logic              memWriteOut,
    output logic [FLAG_W-1:0] ccr,
    output logic [DATA_W-1:0] hiOut,
    output logic              fwdValid,
    output logic [REG_AW-1:0] fwdRd,
    output logic [DATA_W-1:0] fwdData
);

    logic              accept;
    logic [FLAG_W-1:0] flagsIn;

    assign inReady = !outValid || outReady;
    assign accept  = inValid && inReady && !flush;

    assign fwdValid = outValid && regWriteOut;
    assign fwdRd    = rdOut;
    assign fwdData  = resultOut;

    // Pack ALU flags into CCR bit order.
    always_comb begin
        flagsIn        = '0;
        flagsIn[CCR_C] = carryIn;
        flagsIn[CCR_S] = signIn;
        flagsIn[CCR_Z] = zeroIn;
    end

    // Valid bit: flush beats accept, accept beats drain.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            outValid <= 1'b0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (accept) begin
            outValid <= 1'b1;
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

    // Payload registers load only on accept and otherwise hold.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            resultOut    <= '0;
            storeDataOut <= '0;
            rdOut        <= '0;
            regWriteOut  <= 1'b0;
            memReadOut   <= 1'b0;
            memWriteOut  <= 1'b0;
        end else if (accept) begin
            resultOut    <= aluResult;
            storeDataOut <= storeDataIn;
            rdOut        <= rdIn;
            regWriteOut  <= regWriteIn;
            memReadOut   <= memReadIn;
            memWriteOut  <= memWriteIn;
        end
    end

    // HI register written by accepted instructions that produce a high product.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hiOut <= '0;
        end else if (accept && hiWrite) begin
            hiOut <= aluResultExt;
        end
    end

    ccr_unit uCcr (
        .clk        (clk),
        .rstN       (rstN),
        .update     (accept),
        .flagMask   (flagMask),
        .flagsIn    (flagsIn),
        .intSave    (intSave),
        .rtiRestore (rtiRestore),
        .ccr        (ccr)
    );

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline stage directly downstream of the ALU in the Harvard MIPS datapath.
- Registers the ALU result, the extended (high) product and the instruction control bits behind a valid/ready handshake.
- Owns the architectural condition-code register (CCR: carry, sign, zero) and the HI register.
- Holds a one-deep shadow copy of the CCR for interrupt entry and RTI, and drives forwarding outputs back to the decode stage.

Parameters:
- DATA_W, 32, datapath width of result, extended result, store data and HI.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock.
- rstN  in  1  asynchronous active-low reset.
- inValid  in  1  EX holds a valid instruction.
- inReady  out  1  stage can accept this cycle.
- aluResult  in  DATA_W  ALU result.
- aluResultExt  in  DATA_W  ALU high product (MUL only).
- carryIn, signIn, zeroIn  in  1 each  ALU flags.
- flagMask  in  3  per-flag update enable, bit order {C,S,Z}.
- hiWrite  in  1  instruction writes HI from aluResultExt.
- rdIn  in  REG_AW  destination register.
- regWriteIn, memReadIn, memWriteIn  in  1 each  control bits.
- storeDataIn  in  DATA_W  store operand.
- flush  in  1  squash the stage contents and the incoming instruction.
- intSave  in  1  pulse: copy CCR to shadow.
- rtiRestore  in  1  pulse: copy shadow to CCR.
- outValid  out  1  MEM payload valid.
- outReady  in  1  MEM consumes this cycle.
- resultOut, storeDataOut  out  DATA_W  registered payload.
- rdOut  out  REG_AW  registered destination register.
- regWriteOut, memReadOut, memWriteOut  out  1 each  registered control bits.
- ccr  out  3  architectural flags {C,S,Z}.
- hiOut  out  DATA_W  HI register.
- fwdValid  out  1  equals outValid & regWriteOut.
- fwdRd  out  REG_AW  equals rdOut.
- fwdData  out  DATA_W  equals resultOut.

Behaviour:
- Reset (rstN low, asynchronous):
  - outValid, ccr, shadow, hiOut and every payload/control output are 0.
  - Outputs stay 0 until the first rising edge after rstN is released.
- inReady = !outValid | outReady. This is combinational and is the only combinational path, from outReady to inReady.
- Accept: a transfer happens when inValid & inReady & !flush.
  - On the next edge the payload registers load, outValid goes to 1, and latency is 1 cycle.
- Drain: if outValid & outReady and no accept occurs, outValid goes to 0 on the next edge. Payload registers hold their values.
- Stall: if outValid & !outReady, every payload and control register holds and inReady = 0.
- CCR update on accept: each ccr bit whose flagMask bit is 1 loads the matching ALU flag; bits with mask 0 hold.
- HI update on accept with hiWrite = 1: hiOut loads aluResultExt.
- flush has priority over accept:
  - outValid goes to 0 on the next edge.
  - The incoming instruction is dropped and has no CCR or HI side effects.
  - The payload is don't-care but holds.
- intSave: shadow loads ccr as it was before this edge, i.e. any same-cycle flag update is excluded.
- rtiRestore: ccr loads shadow.
  - It overrides any same-cycle flagMask update.
  - HI update in the same cycle still occurs.
- intSave & rtiRestore in the same cycle: the values swap. Shadow gets the old ccr and ccr gets the old shadow.
- Mid-operation reset (rstN asserted while stalled): contents are lost, outValid = 0 immediately, and no handshake is completed.
- No arithmetic inside the block; all widths pass straight through.

Decomposition:
- Shared package: CCR bit indices (C=2, S=1, Z=0), the flag-width constant 3, and DATA_W/REG_AW defaults.
- One natural sub-module, ccr_unit: CCR, shadow, mask and the save/restore priority logic.
- The top level keeps the handshake and payload registers.

Test Plan:
- Reset with rstN = 0 mid-stall -> outValid, ccr, hiOut read 0 immediately; inReady = 1 once released.
- Accept aluResult = 0x0000_0005, rdIn = 3, regWriteIn = 1, outReady = 1 -> next cycle resultOut = 5, rdOut = 3, outValid = 1, fwdValid = 1, fwdData = 5.
- Hold outReady = 0 for 3 cycles with new inValid data -> inReady = 0 and payload unchanged throughout; the first outReady = 1 cycle accepts the new word the next edge.
- flagMask = 3'b101, flags {C,S,Z} = {1,1,0}, ccr = 3'b010 -> ccr = 3'b110 (S held, C and Z loaded). With flush = 1 the same cycle -> ccr stays 3'b010 and outValid = 0.
- MUL with hiWrite = 1, aluResultExt = 0xDEAD_BEEF -> hiOut = 0xDEAD_BEEF next cycle; a following non-hiWrite instruction leaves it unchanged.
- ccr = 3'b001, intSave; then accept flags setting ccr = 3'b100; then rtiRestore concurrent with flagMask = 3'b111 -> ccr = 3'b001. intSave & rtiRestore together with shadow = 3'b001, ccr = 3'b110 -> swap to ccr = 3'b001, shadow = 3'b110.
